// File: rtl/cmul_booth_seq.sv
// ============================================================================
// cmul_booth_seq: complex multiplier controller, four real products through one
// external sequential multiplier. Optional rounding: CMUL_ROUND_EN. Rev 1.0
// ============================================================================
`default_nettype none

module cmul_booth_seq #(
  parameter int N       = 16,
  parameter int SHIFT   = 15,
  parameter int TIMEOUT = 31
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_re,
  input  logic [N-1:0] in_im,
  input  logic [N-1:0] tw_re,
  input  logic [N-1:0] tw_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_re,
  output logic [N-1:0] out_im,
  output logic         sat,
  output logic         err,
  output logic         mul_ld,
  output logic [N-1:0] mul_m,
  output logic [N-1:0] mul_r,
  input  logic         mul_valid,
  input  logic [2*N-1:0] mul_p
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic signed [2*N+1:0] SAT_MAX = {{(N+3){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N+1:0] SAT_MIN = {{(N+3){1'b1}}, {(N-1){1'b0}}};
`ifdef CMUL_ROUND_EN
  localparam logic signed [2*N+1:0] RND = {{(2*N+1){1'b0}}, 1'b1} << (SHIFT-1);
`else
  localparam logic signed [2*N+1:0] RND = '0;
`endif

  state_t state, state_nxt;
  logic [1:0] k;
  logic [7:0] cnt;
  logic [N-1:0] op_in_re, op_in_im, op_tw_re, op_tw_im;
  logic signed [2*N:0] acc_re, acc_im;
  logic signed [2*N:0] p_ext;
  logic accept, timeout;
  logic [N:0] res_re, res_im;

  // Returns {clipped, value}: optional rounding, arithmetic shift, saturate to N bits.
  function automatic logic [N:0] sat_shift(input logic signed [2*N:0] a);
    logic signed [2*N+1:0] t;
    t = ($signed({a[2*N], a}) + RND) >>> SHIFT;
    if (t > SAT_MAX)
      sat_shift = {1'b1, SAT_MAX[N-1:0]};
    else if (t < SAT_MIN)
      sat_shift = {1'b1, SAT_MIN[N-1:0]};
    else
      sat_shift = {1'b0, t[N-1:0]};
  endfunction

  assign accept = in_valid && (state == S_IDLE);
  assign p_ext  = $signed({mul_p[2*N-1], mul_p});

  always_ff @(posedge Clk) begin
    if (Rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_ld    = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mul_ld    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mul_valid)
          state_nxt = (k == 2'd3) ? S_DONE : S_ISSUE;
        else if (cnt == 8'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand pair is a pure function of k, so it stays put from Ld until Valid.
  always_comb begin
    mul_m = op_in_re;
    mul_r = op_tw_re;
    case (k)
      2'd1: begin mul_m = op_in_im; mul_r = op_tw_im; end
      2'd2: begin mul_m = op_in_re; mul_r = op_tw_im; end
      2'd3: begin mul_m = op_in_im; mul_r = op_tw_re; end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      k        <= 2'd0;
      cnt      <= 8'd0;
      err      <= 1'b0;
      op_in_re <= '0;
      op_in_im <= '0;
      op_tw_re <= '0;
      op_tw_im <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
    end else begin
      if (accept) begin
        op_in_re <= in_re;
        op_in_im <= in_im;
        op_tw_re <= tw_re;
        op_tw_im <= tw_im;
        k        <= 2'd0;
        err      <= 1'b0;
      end
      if (state == S_ISSUE)
        cnt <= 8'd0;
      else if (state == S_WAIT)
        cnt <= cnt + 8'd1;
      if (timeout) begin
        err    <= 1'b1;
        acc_re <= '0;
        acc_im <= '0;
      end else if ((state == S_WAIT) && mul_valid) begin
        k <= k + 2'd1;
        case (k)
          2'd0:    acc_re <= p_ext;
          2'd1:    acc_re <= acc_re - p_ext;
          2'd2:    acc_im <= p_ext;
          default: acc_im <= acc_im + p_ext;
        endcase
      end
    end
  end

  assign res_re = sat_shift(acc_re);
  assign res_im = sat_shift(acc_im);
  assign out_re = res_re[N-1:0];
  assign out_im = res_im[N-1:0];
  assign sat    = out_valid && (res_re[N] || res_im[N]);

endmodule

`default_nettype wire
